// File: rtl/updown_seq_checker.sv
// updown_seq_checker
// Receive-side monitor for a bouncing up/down counter stream (count, dir).
// It predicts the successor of every valid sample and locks after LOCK_N
// consecutive correct steps. While locked it flags mismatches, counts them
// with saturation, and counts direction reversals with wrap-around.

module updown_seq_checker #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_count,
    input  logic             in_dir,
    input  logic             in_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] turn_cnt,
    output logic [WIDTH-1:0] exp_count
);

    // The run counter only needs to reach LOCK_N-1, and LOCK_N is at most 15.
    localparam int              RUN_W    = 4;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_N - 1);
    localparam logic [WIDTH-1:0] MAX_C    = '1;
    localparam logic [WIDTH-1:0] MIN_C    = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    // Successor count of a (count, dir) pair. Endpoints reverse explicitly,
    // so the arithmetic never wraps.
    function automatic logic [WIDTH-1:0] succ_count(input logic [WIDTH-1:0] c,
                                                    input logic             d);
        logic [WIDTH-1:0] r;
        if (d) begin
            r = (c == MAX_C) ? (MAX_C - WIDTH'(1)) : (c + WIDTH'(1));
        end else begin
            r = (c == MIN_C) ? WIDTH'(1) : (c - WIDTH'(1));
        end
        return r;
    endfunction

    // Successor direction: flips only when an endpoint is reached.
    function automatic logic succ_dir(input logic [WIDTH-1:0] c,
                                      input logic             d);
        logic r;
        if (d) begin
            r = (c != MAX_C);
        end else begin
            r = (c == MIN_C);
        end
        return r;
    endfunction

    // Saturating increment for the error counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = (v == '1) ? v : (v + CNT_W'(1));
        return r;
    endfunction

    state_t           state_q,     state_d;
    logic [RUN_W-1:0] run_q,       run_d;
    logic [WIDTH-1:0] exp_count_q, exp_count_d;
    logic             exp_dir_q,   exp_dir_d;
    logic             last_dir_q,  last_dir_d;
    logic             locked_q,    locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0] turn_cnt_q,  turn_cnt_d;

    logic             sample_match;
    logic             run_done;

    assign sample_match = (in_count == exp_count_q) && (in_dir == exp_dir_q);
    assign run_done     = (run_q == RUN_LAST);

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            run_q       <= '0;
            exp_count_q <= '0;
            exp_dir_q   <= 1'b0;
            last_dir_q  <= 1'b0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            turn_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            exp_count_q <= exp_count_d;
            exp_dir_q   <= exp_dir_d;
            last_dir_q  <= last_dir_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
        end
    end

    // Next state, run length and prediction. Every valid sample reloads the
    // prediction from itself: on a match this equals advancing the old
    // prediction, on a mismatch it resynchronises to the new stream.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        exp_count_d = exp_count_q;
        exp_dir_d   = exp_dir_q;
        last_dir_d  = last_dir_q;
        if (in_valid) begin
            exp_count_d = succ_count(in_count, in_dir);
            exp_dir_d   = succ_dir(in_count, in_dir);
            last_dir_d  = in_dir;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQ;
                    run_d   = '0;
                end
                ST_ACQ: begin
                    if (sample_match) begin
                        if (run_done) begin
                            state_d = ST_TRACK;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                ST_TRACK: begin
                    if (!sample_match) begin
                        state_d = ST_ACQ;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    // Next values of the registered outputs: lock flag, error pulse and
    // the error / turnaround counters.
    always_comb begin
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        turn_cnt_d  = turn_cnt_q;
        if (in_valid) begin
            case (state_q)
                ST_ACQ: begin
                    if (sample_match && run_done) begin
                        locked_d = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (sample_match) begin
                        if (in_dir != last_dir_q) begin
                            turn_cnt_d = turn_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = sat_inc(err_cnt_q);
                        locked_d    = 1'b0;
                    end
                end
                default: begin
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign turn_cnt  = turn_cnt_q;
    assign exp_count = exp_count_q;

endmodule

// File: tb/tb_updown_seq_checker.sv
// Bench for updown_seq_checker: two instances (8-bit and 2-bit counters)
// share one stimulus stream and are compared each cycle against a
// streak-based reference model, plus literal checkpoints.

module tb_updown_seq_checker;

    localparam int LOCK_N = 3;
    localparam int MAXV   = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_count;
    logic       in_dir;
    logic       in_valid;

    logic       locked,  err_pulse;
    logic [7:0] err_cnt, turn_cnt;
    logic [3:0] exp_count;
    logic       locked2, err_pulse2;
    logic [1:0] err_cnt2, turn_cnt2;
    logic [3:0] exp_count2;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    updown_seq_checker #(.WIDTH(4), .LOCK_N(LOCK_N), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_count(in_count), .in_dir(in_dir),
        .in_valid(in_valid), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .turn_cnt(turn_cnt), .exp_count(exp_count)
    );

    updown_seq_checker #(.WIDTH(4), .LOCK_N(LOCK_N), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_count(in_count), .in_dir(in_dir),
        .in_valid(in_valid), .locked(locked2), .err_pulse(err_pulse2),
        .err_cnt(err_cnt2), .turn_cnt(turn_cnt2), .exp_count(exp_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Producer protocol successor, in plain integers.
    function automatic int nxt_c(input int c, input int d);
        if (d == 1) return (c == MAXV) ? MAXV - 1 : c + 1;
        else        return (c == 0) ? 1 : c - 1;
    endfunction

    function automatic int nxt_d(input int c, input int d);
        if (d == 1) return (c == MAXV) ? 0 : 1;
        else        return (c == 0) ? 1 : 0;
    endfunction

    // Reference model: the checker is locked exactly when the last LOCK_N
    // valid samples each followed their predecessor, counted from the most
    // recent break. Errors and turns are kept unbounded and folded to the
    // counter width at compare time.
    bit m_seen, m_pulse;
    int m_streak, m_pc, m_pd, m_ld, m_err, m_turn;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_seen = 0; m_pulse = 0; m_streak = 0;
            m_pc = 0; m_pd = 0; m_ld = 0; m_err = 0; m_turn = 0;
        end else begin
            m_pulse = 0;
            if (in_valid) begin
                if (!m_seen) begin
                    m_seen   = 1;
                    m_streak = 0;
                end else if (int'(in_count) == m_pc && int'(in_dir) == m_pd) begin
                    if (m_streak >= LOCK_N && int'(in_dir) != m_ld) m_turn++;
                    if (m_streak < 1000) m_streak++;
                end else begin
                    if (m_streak >= LOCK_N) begin
                        m_err++;
                        m_pulse = 1;
                    end
                    m_streak = 0;
                end
                m_pc = nxt_c(int'(in_count), int'(in_dir));
                m_pd = nxt_d(int'(in_count), int'(in_dir));
                m_ld = int'(in_dir);
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("locked",     int'(locked),     (m_streak >= LOCK_N) ? 1 : 0);
            chk("err_pulse",  int'(err_pulse),  int'(m_pulse));
            chk("err_cnt",    int'(err_cnt),    (m_err > 255) ? 255 : m_err);
            chk("turn_cnt",   int'(turn_cnt),   m_turn % 256);
            chk("exp_count",  int'(exp_count),  m_pc);
            chk("locked2",    int'(locked2),    (m_streak >= LOCK_N) ? 1 : 0);
            chk("err_pulse2", int'(err_pulse2), int'(m_pulse));
            chk("err_cnt2",   int'(err_cnt2),   (m_err > 3) ? 3 : m_err);
            chk("turn_cnt2",  int'(turn_cnt2),  m_turn % 4);
        end
    end

    int s_c, s_d;

    task automatic send(input int c, input int d);
        in_count = 4'(c);
        in_dir   = d[0];
        in_valid = 1'b1;
        @(posedge clk);
        #2;
    endtask

    // Send the current clean-stream pair n times, advancing each time.
    task automatic adv_n(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            send(s_c, s_d);
            t   = s_c;
            s_c = nxt_c(t, s_d);
            s_d = nxt_d(t, s_d);
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_count = 4'($urandom_range(0, 15));
            in_dir   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_count = 4'd0;
        in_dir   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b1;
        reset  = 1'b0;

        // Reset state
        chk("rst_locked",   int'(locked),    0);
        chk("rst_err_cnt",  int'(err_cnt),   0);
        chk("rst_turn_cnt", int'(turn_cnt),  0);
        chk("rst_exp",      int'(exp_count), 0);
        chk("rst_pulse",    int'(err_pulse), 0);

        // Clean stream from (0,1): lock on the 4th sample
        s_c = 0; s_d = 1;
        adv_n(3);
        chk("acq_not_locked", int'(locked), 0);
        adv_n(1);
        chk("lock_4th", int'(locked), 1);
        chk("lock_exp", int'(exp_count), 4);
        adv_n(12);                         // up to (15,1)
        chk("top_no_turn", int'(turn_cnt), 0);
        adv_n(1);                          // (14,0)
        chk("top_turn", int'(turn_cnt), 1);
        chk("top_no_err", int'(err_cnt), 0);
        adv_n(14);                         // down to (0,0)
        chk("bot_turn_hold", int'(turn_cnt), 1);
        adv_n(1);                          // (1,1)
        chk("bot_turn", int'(turn_cnt), 2);
        chk("sweep_err", int'(err_cnt), 0);
        chk("sweep_exp", int'(exp_count), 2);

        // Valid gaps with garbage on the inputs
        adv_n(3);                          // (2..4,1)
        gap(5);
        chk("gap_locked", int'(locked), 1);
        chk("gap_exp", int'(exp_count), 5);
        adv_n(3);                          // (5..7,1)
        chk("gap_err", int'(err_cnt), 0);

        // Injected fault at (7,1) -> (9,1)
        send(9, 1);
        chk("fault_pulse", int'(err_pulse), 1);
        chk("fault_err",   int'(err_cnt), 1);
        chk("fault_unlock", int'(locked), 0);
        s_c = 10; s_d = 1;
        adv_n(1);
        chk("fault_pulse_once", int'(err_pulse), 0);
        adv_n(1);
        chk("relock_pending", int'(locked), 0);
        adv_n(1);                          // (12,1)
        chk("relock", int'(locked), 1);

        // Four more faults: 2-bit err counter saturates, pulse continues
        for (int k = 0; k < 4; k++) begin
            send((s_c + 3) % 16, s_d);
            chk("sat_pulse2", int'(err_pulse2), 1);
            s_c = nxt_c((s_c + 3) % 16, s_d);
            s_d = nxt_d((s_c + 16 - 1) % 16, s_d) == 0 ? s_d : s_d;
            // recompute direction cleanly from the sent fault pair
            s_d = in_dir;
            s_d = nxt_d(int'(in_count), int'(in_dir));
            adv_n(3);
            chk("sat_relock", int'(locked2), 1);
        end
        chk("sat_err2", int'(err_cnt2), 3);
        chk("sat_err8", int'(err_cnt), 5);

        // Asynchronous reset between edges while locked
        chk("pre_rst_locked", int'(locked), 1);
        reset = 1'b1;
        #1;
        chk("arst_locked", int'(locked), 0);
        chk("arst_err",    int'(err_cnt), 0);
        chk("arst_turn",   int'(turn_cnt), 0);
        chk("arst_err2",   int'(err_cnt2), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Re-lock after release takes LOCK_N+1 samples; then 5 turnarounds
        s_c = 13; s_d = 1;
        adv_n(3);                          // (13,1),(14,1),(15,1)
        chk("rerelock_pending", int'(locked), 0);
        adv_n(1);                          // (14,0): locks, not a counted turn
        chk("rerelock", int'(locked), 1);
        chk("rerelock_turn", int'(turn_cnt), 0);
        adv_n(15);
        chk("wrap_turn1", int'(turn_cnt), 1);
        adv_n(60);
        chk("wrap_turn5", int'(turn_cnt), 5);
        chk("wrap_turn2", int'(turn_cnt2), 1);
        chk("wrap_err", int'(err_cnt), 0);

        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
